// File: rtl/pipelined_adder.sv
// Multi-lane pipelined adder/subtractor with wrap and saturate modes.
// Each lane splits its carry chain: low half in stage 0, high half in
// stage 1, saturation in the last stage. Valid/ready handshake on both
// sides; the pipeline compresses bubbles under backpressure.
module pipelined_adder #(
    parameter int WIDTH  = 4,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [1:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] sum,
    output logic [LANES-1:0]       carry,
    output logic [LANES-1:0]       ovf
);

    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SADD = 2'b10,
        OP_UADD = 2'b11
    } op_e;

    // Per-lane payload carried down the pipe. bx is b, or ~b for subtract.
    // r/c hold the partial (then full, then saturated) sum and its carry.
    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             ov;
    } lane_t;

    lane_t             st_q [STAGES][LANES];
    lane_t             st_d [STAGES][LANES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // Low half of the carry chain; subtract injects the +1 here.
    function automatic lane_t f_lo(input op_e o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        lane_t        t;
        logic [LO:0]  s;
        t    = '0;
        t.op = o;
        t.a  = x;
        t.bx = (o == OP_SUB) ? ~y : y;
        s    = {1'b0, t.a[LO-1:0]} + {1'b0, t.bx[LO-1:0]} + {{LO{1'b0}}, (o == OP_SUB)};
        t.r[LO-1:0] = s[LO-1:0];
        t.c         = s[LO];
        return t;
    endfunction

    // High half of the carry chain, consuming the low-half carry.
    function automatic lane_t f_hi(input lane_t t_in);
        lane_t       t;
        logic [HI:0] s;
        t = t_in;
        s = {1'b0, t.a[WIDTH-1:LO]} + {1'b0, t.bx[WIDTH-1:LO]} + {{HI{1'b0}}, t.c};
        t.r[WIDTH-1:LO] = s[HI-1:0];
        t.c             = s[HI];
        return t;
    endfunction

    // Overflow detection and clamping on the completed sum.
    function automatic lane_t f_sat(input lane_t t_in);
        lane_t t;
        logic  sov;
        t   = t_in;
        sov = (t.a[WIDTH-1] == t.bx[WIDTH-1]) && (t.r[WIDTH-1] != t.a[WIDTH-1]);
        case (t.op)
            OP_SADD: begin
                t.ov = sov;
                if (sov) begin
                    t.r = t.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            OP_UADD: begin
                t.ov = t.c;
                if (t.c) begin
                    t.r = '1;
                end
            end
            default: t.ov = sov;
        endcase
        return t;
    endfunction

    // Advance chain: a stage moves when everything above it can make room.
    always_comb begin : p_adv
        logic go;
        // NOTE: blocking '=' in combinational blocks; go is a running value
        // evaluated top stage down, so order of assignment matters here.
        go = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = vld_q[k] && go;
            go     = go || !vld_q[k];
        end
    end

    assign in_ready  = !vld_q[0] || adv[0];
    assign out_valid = vld_q[STAGES-1];

    // Stage load enables: stage 0 from the input handshake, others from below.
    always_comb begin
        load    = '0;
        load[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Next payload for every stage and lane.
    always_comb begin : p_datapath
        lane_t cur;
        // NOTE: every combinational output gets a value on every path (here
        // the loops cover all elements) so no latches are inferred.
        for (int l = 0; l < LANES; l++) begin
            cur = f_lo(op_e'(op), a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH]);
            if (STAGES == 1) begin
                cur = f_sat(f_hi(cur));
            end
            st_d[0][l] = cur;
            for (int k = 1; k < STAGES; k++) begin
                cur = st_q[k-1][l];
                if (k == 1) begin
                    cur = f_hi(cur);
                end
                if (k == STAGES - 1) begin
                    cur = f_sat(cur);
                end
                st_d[k][l] = cur;
            end
        end
    end

    // Stage valid bits: set on load, cleared when the occupant leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k] <= 1'b1;
                end else if (adv[k]) begin
                    vld_q[k] <= 1'b0;
                end
            end
        end
    end

    // Stage payload registers; held while a stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset (not just the valid bits)
            // because sum/carry/ovf must read zero straight out of reset.
            for (int k = 0; k < STAGES; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    st_q[k][l] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    for (int l = 0; l < LANES; l++) begin
                        st_q[k][l] <= st_d[k][l];
                    end
                end
            end
        end
    end

    // Unpack the last stage onto the result ports.
    always_comb begin
        sum   = '0;
        carry = '0;
        ovf   = '0;
        for (int l = 0; l < LANES; l++) begin
            sum[l*WIDTH +: WIDTH] = st_q[STAGES-1][l].r;
            carry[l]              = st_q[STAGES-1][l].c;
            ovf[l]                = st_q[STAGES-1][l].ov;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a 4-bit single-lane 2-stage instance
// and an 8-bit four-lane 3-stage instance sharing clock and reset.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 4-bit, 1 lane, 2 stages
    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic [1:0] op4_i = '0;
    logic [0:0] carry4, ovf4;

    // 8-bit, 4 lanes, 3 stages
    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [31:0] a8 = '0, b8 = '0, sum8;
    logic [1:0]  op8_i = '0;
    logic [3:0]  carry8, ovf8;

    pipelined_adder #(.WIDTH(4), .LANES(1), .STAGES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4_i), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .carry(carry4), .ovf(ovf4)
    );

    pipelined_adder #(.WIDTH(8), .LANES(4), .STAGES(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8_i), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry(carry8), .ovf(ovf8)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    typedef struct packed {
        logic [31:0] s;
        logic [3:0]  c;
        logic [3:0]  v;
    } exp_t;

    exp_t exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference for one 8-bit lane, written from the arithmetic definitions.
    function automatic res_t model8(input logic [1:0] o, input int x, input int y);
        res_t r;
        int   sx, sy, full, ss;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        r  = '0;
        case (o)
            2'b00: begin
                full = x + y; r.s = full[7:0]; r.c = full[8];
                ss = sx + sy; r.v = (ss > 127) || (ss < -128);
            end
            2'b01: begin
                full = x - y; r.s = full[7:0]; r.c = (x >= y);
                ss = sx - sy; r.v = (ss > 127) || (ss < -128);
            end
            2'b10: begin
                full = x + y; r.c = full[8];
                ss = sx + sy;
                if (ss > 127) begin r.s = 8'h7F; r.v = 1'b1; end
                else if (ss < -128) begin r.s = 8'h80; r.v = 1'b1; end
                else begin r.s = ss[7:0]; r.v = 1'b0; end
            end
            default: begin
                full = x + y;
                if (full > 255) begin r.s = 8'hFF; r.v = 1'b1; r.c = 1'b1; end
                else begin r.s = full[7:0]; r.v = 1'b0; r.c = 1'b0; end
            end
        endcase
        return r;
    endfunction

    // One op on the 4-bit instance, checking the 2-cycle latency and result.
    task automatic run4(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] es, input logic ec, input logic ev, input string tag);
        @(negedge clk);
        op4_i = o; a4 = x; b4 = y; in_valid4 = 1'b1;
        #1 check({tag, " in_ready"}, in_ready4, 1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        @(negedge clk);
        check({tag, " early out_valid"}, out_valid4, 0);
        @(negedge clk);
        check({tag, " out_valid"}, out_valid4, 1);
        check({tag, " sum"}, sum4, es);
        check({tag, " carry"}, carry4, ec);
        check({tag, " ovf"}, ovf4, ev);
    endtask

    // One op on the four-lane instance, checking the 3-cycle latency.
    task automatic run8(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] es, input logic [3:0] ec, input logic [3:0] ev,
                        input string tag);
        @(negedge clk);
        op8_i = o; a8 = x; b8 = y; in_valid8 = 1'b1;
        #1 check({tag, " in_ready"}, in_ready8, 1);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check({tag, " early out_valid"}, out_valid8, 0);
        end
        @(negedge clk);
        check({tag, " out_valid"}, out_valid8, 1);
        check({tag, " sum"}, sum8, es);
        check({tag, " carry"}, carry8, ec);
        check({tag, " ovf"}, ovf8, ev);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst out_valid4", out_valid4, 0);
        check("rst sum4", sum4, 0);
        check("rst carry4", carry4, 0);
        check("rst ovf4", ovf4, 0);
        check("rst out_valid8", out_valid8, 0);
        check("rst sum8", sum8, 0);
        check("rst carry8/ovf8", {carry8, ovf8}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready4", in_ready4, 1);
        check("post-rst in_ready8", in_ready8, 1);

        // Single-lane arithmetic
        run4(2'b00, 4'd5, 4'd6,  4'd11, 1'b0, 1'b1, "add 5+6");
        run4(2'b00, 4'd9, 4'd8,  4'd1,  1'b1, 1'b1, "add 9+8");
        run4(2'b11, 4'd9, 4'd8,  4'd15, 1'b1, 1'b1, "usat 9+8");
        run4(2'b01, 4'd3, 4'd5,  4'd14, 1'b0, 1'b0, "sub 3-5");
        run4(2'b01, 4'd7, 4'd2,  4'd5,  1'b1, 1'b0, "sub 7-2");
        run4(2'b10, 4'd7, 4'd1,  4'd7,  1'b0, 1'b1, "ssat 7+1");
        run4(2'b10, 4'd8, 4'd15, 4'd8,  1'b1, 1'b1, "ssat -8+-1");
        run4(2'b11, 4'd3, 4'd4,  4'd7,  1'b0, 1'b0, "usat 3+4");

        // Four independent lanes
        run8(2'b10, 32'hFF109070, 32'h01059020, 32'h0015807F, 4'b1010, 4'b0011, "lanes ssat");
        run8(2'b11, 32'h008010F0, 32'h00802020, 32'h00FF30FF, 4'b0101, 4'b0101, "lanes usat");
        run8(2'b01, 32'h01008005, 32'h02010103, 32'hFFFF7F02, 4'b0011, 4'b0010, "lanes sub");

        // Backpressure: fill both stages, hold, then drain with a same-cycle accept
        @(negedge clk);
        out_ready4 = 1'b0;
        op4_i = 2'b00; a4 = 4'd1; b4 = 4'd2; in_valid4 = 1'b1;
        #1 check("bp in_ready empty", in_ready4, 1);
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd4;
        #1 check("bp in_ready one held", in_ready4, 1);
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd6;
        #1 check("bp in_ready full", in_ready4, 0);
        check("bp out_valid", out_valid4, 1);
        check("bp sum held", sum4, 4'd3);
        @(negedge clk);
        check("bp sum stable", sum4, 4'd3);
        check("bp in_ready still full", in_ready4, 0);
        out_ready4 = 1'b1;
        #1 check("bp in_ready full draining", in_ready4, 1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        @(negedge clk);
        check("bp second valid", out_valid4, 1);
        check("bp second sum", sum4, 4'd7);
        @(negedge clk);
        check("bp third valid", out_valid4, 1);
        check("bp third sum", sum4, 4'd11);
        check("bp third ovf", ovf4, 1);
        @(negedge clk);
        check("bp drained", out_valid4, 0);

        // Reset with two ops in flight
        @(negedge clk);
        op4_i = 2'b00; a4 = 4'd2; b4 = 4'd2; in_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd4; b4 = 4'd4;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        check("flight out_valid", out_valid4, 1);
        check("flight sum", sum4, 4'd4);
        #1 rst_n = 1'b0;
        #1 check("async rst out_valid", out_valid4, 0);
        check("async rst sum", sum4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no stale result", out_valid4, 0);
        end
        run4(2'b00, 4'd6, 4'd3, 4'd9, 1'b0, 1'b1, "after rst 6+3");

        // Streamed scoreboard run with random downstream stalls
        begin
            int   sent, got, occ;
            logic acc, del;
            exp_t e, g;
            res_t r;
            sent = 0; got = 0; occ = 0;
            for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
                @(negedge clk);
                out_ready8 = 1'($urandom_range(0, 1));
                if (!in_valid8 && sent < 20) begin
                    op8_i = 2'($urandom_range(0, 3));
                    a8 = $urandom;
                    b8 = $urandom;
                    in_valid8 = 1'b1;
                end
                #1;
                check("stream in_ready", in_ready8, !(occ == 3 && !out_ready8));
                acc = in_valid8 && in_ready8;
                del = out_valid8 && out_ready8;
                if (acc) begin
                    for (int l = 0; l < 4; l++) begin
                        r = model8(op8_i, int'(a8[l*8 +: 8]), int'(b8[l*8 +: 8]));
                        e.s[l*8 +: 8] = r.s;
                        e.c[l] = r.c;
                        e.v[l] = r.v;
                    end
                    exp_q.push_back(e);
                    sent++;
                end
                if (del) begin
                    g = '{s: sum8, c: carry8, v: ovf8};
                    if (exp_q.size() == 0) begin
                        check("stream unexpected result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream result", g, e);
                    end
                    got++;
                end
                occ = occ + int'(acc) - int'(del);
                @(posedge clk);
                #1 if (acc) in_valid8 = 1'b0;
            end
            check("stream results delivered", got, 20);
            check("stream queue empty", exp_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
